instr_encoder: RTL and testbench

Sequential MIPS instruction encoder: the inverse of the control decoder. It accepts instruction fields (kind, registers, funct, immediate, jump target) over a valid/ready handshake, packs them into 32-bit MIPS words and writes them sequentially into instruction memory. It is used by test harnesses and boot loaders to place programs in imem before the single-cycle core is released from reset.

---
 rtl/mips_isa_pkg.sv | 30 +++
 rtl/instr_pack.sv | 49 ++++
 rtl/instr_encoder.sv | 120 ++++++++++++
 tb/tb_instr_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder and the control decoder.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    K_RTYPE = 3'd0, K_LW = 3'd1, K_SW = 3'd2, K_BEQ = 3'd3,
    K_BNE = 3'd4, K_ADDI = 3'd5, K_J = 3'd6, K_RSVD = 3'd7
  } kind_e;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} enc_state_e;

  function automatic logic [31:0] fmt_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: kind + fields -> 32-bit MIPS word and illegal flag.
// ENCODER_CHECK_EN restricts R-type funct to add/sub/and/or/slt.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  logic funct_ok;

`ifdef ENCODER_CHECK_EN
  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok = 1'b1;
      default:                               funct_ok = 1'b0;
    endcase
  end
`else
  assign funct_ok = 1'b1;
`endif

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (kind_e'(kind))
      K_RTYPE: begin
        word    = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
        illegal = !funct_ok;
      end
      K_LW:    word = fmt_i(OP_LW, rs, rt, imm);
      K_SW:    word = fmt_i(OP_SW, rs, rt, imm);
      K_BEQ:   word = fmt_i(OP_BEQ, rs, rt, imm);
      K_BNE:   word = fmt_i(OP_BNE, rs, rt, imm);
      K_ADDI:  word = fmt_i(OP_ADDI, rs, rt, imm);
      K_J:     word = {OP_J, target};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential MIPS encoder: accepts field bundles and writes packed words to imem.
// Optional funct checking via ENCODER_CHECK_EN (see instr_pack).
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [2:0]    in_kind,
  input  logic [4:0]    in_rs,
  input  logic [4:0]    in_rt,
  input  logic [4:0]    in_rd,
  input  logic [5:0]    in_funct,
  input  logic [15:0]   in_imm,
  input  logic [25:0]   in_target,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wd,
  output logic [AW:0]   count,
  output logic          full,
  output logic          done,
  output logic          err
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  enc_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] wd_q, wd_d;
  logic        last_q, last_d;
  logic [AW:0] count_q, count_d;
  logic        err_q, err_d;

  logic [31:0] pack_word;
  logic        pack_illegal;
  logic [AW:0] count_nxt;
  logic        accept;

  instr_pack u_pack (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // Gate on the count after the pending write lands, so a full memory never wraps.
  assign count_nxt = count_q + (AW+1)'(we_q);
  assign in_ready  = (state_q == S_LOAD) && (count_nxt != DEPTH) && !start;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    wd_d    = wd_q;
    last_d  = 1'b0;
    count_d = count_q;
    err_d   = err_q;

    if (we_q && count_q != DEPTH) count_d = count_q + (AW+1)'(1);

    if (accept) begin
      we_d   = !pack_illegal;
      last_d = in_last;
      err_d  = err_q | pack_illegal;
      if (!pack_illegal) wd_d = pack_word;
    end

    case (state_q)
      S_LOAD:  if (last_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = state_q;
    endcase

    // start wins over everything, including a write already in flight.
    if (start) begin
      state_d = S_LOAD;
      we_d    = 1'b0;
      last_d  = 1'b0;
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      wd_q    <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      last_q  <= last_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign imem_we   = we_q && !start;
  assign imem_addr = count_q[AW-1:0];
  assign imem_wd   = wd_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (AW=2): vector table plus multi-cycle sequences.
module tb_instr_encoder;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_last;
  logic          in_ready;
  logic [2:0]    in_kind;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic [AW:0]   count;
  logic          full, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wd(imem_wd), .count(count), .full(full), .done(done),
    .err(err)
  );

  typedef struct {
    string       name;
    logic [2:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp_wd;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[12];

`ifdef ENCODER_CHECK_EN
  localparam logic FN0_ILL = 1'b1;
`else
  localparam logic FN0_ILL = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tg, input logic last);
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = fn; in_imm = imm; in_target = tg; in_last = last;
  endtask

  initial begin
    vecs[0]  = '{"addi",      3'd5, 5'd0,  5'd8,  5'd0,  6'h00, 16'h0005, 26'h0,       32'h20080005, 1'b0};
    vecs[1]  = '{"add",       3'd0, 5'd8,  5'd9,  5'd10, 6'h20, 16'h0,    26'h0,       32'h01095020, 1'b0};
    vecs[2]  = '{"j",         3'd6, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0,    26'h0000010, 32'h08000010, 1'b0};
    vecs[3]  = '{"lw",        3'd1, 5'd29, 5'd8,  5'd0,  6'h00, 16'h0004, 26'h0,       32'h8FA80004, 1'b0};
    vecs[4]  = '{"sw",        3'd2, 5'd29, 5'd31, 5'd0,  6'h00, 16'hFFFC, 26'h0,       32'hAFBFFFFC, 1'b0};
    vecs[5]  = '{"beq",       3'd3, 5'd1,  5'd2,  5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h1022FFFF, 1'b0};
    vecs[6]  = '{"bne",       3'd4, 5'd3,  5'd0,  5'd0,  6'h00, 16'h0010, 26'h0,       32'h14600010, 1'b0};
    vecs[7]  = '{"sub",       3'd0, 5'd1,  5'd2,  5'd3,  6'h22, 16'h0,    26'h0,       32'h00221822, 1'b0};
    vecs[8]  = '{"rsvd",      3'd7, 5'd1,  5'd2,  5'd3,  6'h20, 16'h1234, 26'h0,       32'h0,        1'b1};
    vecs[9]  = '{"funct0",    3'd0, 5'd8,  5'd9,  5'd10, 6'h00, 16'h0,    26'h0,       32'h01095000, FN0_ILL};
    vecs[10] = '{"addi_junk", 3'd5, 5'd31, 5'd31, 5'd5,  6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h23FFFFFF, 1'b0};
    vecs[11] = '{"j_junk",    3'd6, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h0BFFFFFF, 1'b0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0; in_imm = '0; in_target = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we",    32'(imem_we),  32'd0);
    chk("rst_addr",  32'(imem_addr), 32'd0);
    chk("rst_wd",    imem_wd,       32'd0);
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_flags", {28'd0, full, done, err, 1'b0}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    chk("idle_ready", 32'(in_ready), 32'd0);

    // Table: one single-word program per vector.
    for (int i = 0; i < 12; i++) begin
      pulse_start();
      drive(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].funct,
            vecs[i].imm, vecs[i].target, 1'b1);
      @(negedge clk);
      chk({vecs[i].name, "_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk({vecs[i].name, "_we"}, 32'(imem_we), 32'(!vecs[i].exp_ill));
      chk({vecs[i].name, "_addr"}, 32'(imem_addr), 32'd0);
      if (!vecs[i].exp_ill) chk({vecs[i].name, "_wd"}, imem_wd, vecs[i].exp_wd);
      chk({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_ill));
      tick();
      chk({vecs[i].name, "_done"}, 32'(done), 32'd1);
      chk({vecs[i].name, "_count"}, 32'(count), vecs[i].exp_ill ? 32'd0 : 32'd1);
      tick();
      chk({vecs[i].name, "_done_off"}, 32'(done), 32'd0);
    end

    // err is sticky until start (last vector was legal, so check after a reserved one).
    pulse_start();
    drive(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_count", 32'(count), 32'd0);
    chk("err_no_done", 32'(done), 32'd0);
    pulse_start();
    chk("err_clear", 32'(err), 32'd0);

    // Back-to-back writes: add then j.
    drive(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0, 1'b0);
    tick();
    drive(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000010, 1'b1);
    @(negedge clk);
    chk("b2b_we0", 32'(imem_we), 32'd1);
    chk("b2b_addr0", 32'(imem_addr), 32'd0);
    chk("b2b_wd0", imem_wd, 32'h01095020);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_we1", 32'(imem_we), 32'd1);
    chk("b2b_addr1", 32'(imem_addr), 32'd1);
    chk("b2b_wd1", imem_wd, 32'h08000010);
    tick();
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_count", 32'(count), 32'd2);
    tick();

    // Fill the 4-word memory with valid held high; the 5th bundle must stall.
    begin
      int nw = 0, nacc = 0;
      logic acc;
      pulse_start();
      drive(3'd5, 5'd0, 5'd8, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        acc = in_ready;
        if (imem_we) begin
          chk("full_addr", 32'(imem_addr), 32'(nw));
          chk("full_wd", imem_wd, 32'h20080000 | 32'(nw));
          nw++;
        end
        tick();
        if (acc) begin
          nacc++;
          in_imm = in_imm + 16'd1;
        end
      end
      chk("full_writes", 32'(nw), 32'd4);
      chk("full_accepts", 32'(nacc), 32'd4);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_ready", 32'(in_ready), 32'd0);
      chk("full_count", 32'(count), 32'd4);
      in_valid = 1'b0;
      pulse_start();
      chk("full_clear", 32'(full), 32'd0);
      chk("full_clear_cnt", 32'(count), 32'd0);
    end

    // start in the cycle after acceptance cancels the pending write.
    drive(3'd5, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("cancel_we", 32'(imem_we), 32'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("cancel_we2", 32'(imem_we), 32'd0);
    chk("cancel_count", 32'(count), 32'd0);
    chk("cancel_load", 32'(in_ready), 32'd1);
    tick();
    chk("cancel_no_done", 32'(done), 32'd0);

    // Asynchronous reset with a write pending.
    drive(3'd5, 5'd0, 5'd8, 5'd0, 6'd0, 16'h0007, 26'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_we", 32'(imem_we), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_wd", imem_wd, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
